// File: rtl/delayed_sync_pkg.sv
// Shared definitions for the delayed-register synchronisation scheduler:
// FSM state encoding and default sizing.
package delayed_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEF_NUM_REGS       = 4;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage : delayed_sync_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request bit found
// searching upward from i_ptr+1 with wrap-around.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_grant_valid,
  output logic [IW-1:0] o_grant_idx
);

  // Each requester is ranked by its distance past the pointer; the smallest
  // distance wins, so the last granted index naturally gets lowest priority.
  always_comb begin
    int best_d;
    int d;
    // NOTE: every output and local gets a default before any conditional
    // assignment, otherwise synthesis infers a latch to hold the old value.
    o_grant_valid = 1'b0;
    o_grant_idx   = '0;
    best_d        = N;
    d             = 0;
    for (int j = 0; j < N; j++) begin
      if (i_req[j]) begin
        d = (j + N - 1 - int'(i_ptr)) % N;
        if (d < best_d) begin
          best_d        = d;
          o_grant_valid = 1'b1;
          o_grant_idx   = IW'(j);
        end
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/delayed_reg_sync_sched.sv
// Tracks MMIO writes to delayed registers and pushes them to the eFPGA fabric
// one at a time, round-robin, with acknowledge timeout and core write stall.
module delayed_reg_sync_sched
  import delayed_sync_pkg::*;
#(
  parameter int NUM_REGS       = DEF_NUM_REGS,
  parameter int IDX_W          = 2,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wenable,
  input  logic                isMMIO,
  input  logic                isdelayed,
  input  logic                instr_exed,
  input  logic [IDX_W-1:0]    wr_idx,
  output logic                cpu_stall,
  output logic                upd_req,
  output logic [IDX_W-1:0]    upd_idx,
  input  logic                delayed_valid,
  output logic                sync_valid,
  output logic [IDX_W-1:0]    sync_idx,
  output logic [NUM_REGS-1:0] pending,
  output logic                busy,
  output logic                timeout_err,
  output logic [IDX_W-1:0]    timeout_idx,
  input  logic                err_clr
);

  localparam int PAD_W = 1 << IDX_W;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_REGS-1:0]  r_pending;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     r_upd_idx;
  logic [IDX_W-1:0]     r_timeout_idx;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_timeout_err;

  logic                 w_wr;
  logic                 w_idx_ok;
  logic                 w_stall;
  logic                 w_capture;
  logic                 w_done;
  logic                 w_timeout;
  logic                 w_grant_valid;
  logic [IDX_W-1:0]     w_grant_idx;
  logic [PAD_W-1:0]     w_pend_pad;
  logic [NUM_REGS-1:0]  w_set_mask;
  logic [NUM_REGS-1:0]  w_clr_mask;

  // Out-of-range indices read a zero pad bit, so they never stall or capture.
  assign w_pend_pad = PAD_W'(r_pending);
  assign w_wr       = wenable & isMMIO & isdelayed & instr_exed;
  assign w_idx_ok   = ({1'b0, wr_idx} < (IDX_W + 1)'(NUM_REGS));
  assign w_stall    = w_wr & w_idx_ok & w_pend_pad[wr_idx];
  assign w_capture  = w_wr & w_idx_ok & ~w_stall;
  assign w_done     = (r_state == ST_DONE);
  assign w_timeout  = (r_state == ST_WAIT) & ~delayed_valid &
                      (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  rr_arbiter #(
    .N  (NUM_REGS),
    .IW (IDX_W)
  ) u_arb (
    .i_req         (r_pending),
    .i_ptr         (r_ptr),
    .o_grant_valid (w_grant_valid),
    .o_grant_idx   (w_grant_idx)
  );

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_capture && (wr_idx == IDX_W'(i)))
        w_set_mask[i] = 1'b1;
      if ((w_done || w_timeout) && (r_upd_idx == IDX_W'(i)))
        w_clr_mask[i] = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_grant_valid) w_state_nxt = ST_REQ;
      ST_REQ:  w_state_nxt = ST_WAIT;
      // Acknowledge is tested first so it beats a same-cycle timeout.
      ST_WAIT: begin
        if (delayed_valid)  w_state_nxt = ST_DONE;
        else if (w_timeout) w_state_nxt = ST_IDLE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending     <= '0;
      r_ptr         <= IDX_W'(NUM_REGS - 1);
      r_upd_idx     <= '0;
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
      r_timeout_idx <= '0;
    end else begin
      r_pending <= (r_pending | w_set_mask) & ~w_clr_mask;

      if ((r_state == ST_IDLE) && w_grant_valid) begin
        r_upd_idx <= w_grant_idx;
        r_ptr     <= w_grant_idx;
      end

      if (r_state == ST_REQ)       r_cnt <= '0;
      else if (r_state == ST_WAIT) r_cnt <= r_cnt + 1'b1;

      if (w_timeout) begin
        r_timeout_err <= 1'b1;
        r_timeout_idx <= r_upd_idx;
      end else if (err_clr) begin
        r_timeout_err <= 1'b0;
      end
    end
  end

  assign cpu_stall   = w_stall;
  assign upd_req     = (r_state == ST_REQ);
  assign upd_idx     = r_upd_idx;
  assign sync_valid  = w_done;
  assign sync_idx    = r_upd_idx;
  assign pending     = r_pending;
  assign busy        = (r_state != ST_IDLE);
  assign timeout_err = r_timeout_err;
  assign timeout_idx = r_timeout_idx;

endmodule : delayed_reg_sync_sched
